branch_resolution_unit: RTL and testbench
=========================================

// Module: branch_resolution_unit
// PURPOSE
// - Resolves branches at EX/MEM against the prediction made at fetch; on a mispredict it squashes
//   wrong-path stages and redirects fetch to the correct PC through a valid/ready handshake.
// - Issues BTB/BHT training requests. Sits between the EX/MEM register and the fetch PC mux.
// PARAMETERS
// - PC_WIDTH      12  width of all PC/target buses (byte address)
// - DRAIN_CYCLES  2   cycles flush stays asserted after the redirect handshake (range 1..15)
// - CNT_WIDTH     16  width of performance counters (macro-gated)
// PORTS
// - clk               in  1         rising-edge clock
// - reset             in  1         asynchronous, active-high reset
// - ex_mem_valid      in  1         EX/MEM holds a live instruction
// - ex_mem_pc         in  PC_WIDTH  PC of that instruction
// - ex_mem_branch     in  1         instruction is a branch/jump
// - ex_mem_taken      in  1         resolved direction (ignored when !ex_mem_branch)
// - ex_mem_target     in  PC_WIDTH  resolved target
// - ex_mem_pred_taken in  1         direction predicted at fetch
// - ex_mem_pred_target in PC_WIDTH  target predicted at fetch
// - ex_mem_btb_hit    in  1         BTB hit at fetch
// - redirect_ready    in  1         fetch accepts redirect this cycle
// - redirect_valid    out 1         redirect request pending
// - redirect_pc       out PC_WIDTH  corrected fetch PC
// - flush             out 1         squash IF/ID and ID/EX contents
// - busy              out 1         state != IDLE
// - train_valid       out 1         one-cycle training strobe to predictor
// - train_taken       out 1         actual direction for training
// - train_alloc       out 1         1 = allocate/refresh BTB, 0 = no BTB write
// - train_invalidate  out 1         1 = invalidate BTB entry at ex_mem_pc
// BEHAVIOUR
// - Reset: state=IDLE; redirect_valid=0, redirect_pc=0, flush=0, busy=0, train_*=0, counters=0.
// - actual = ex_mem_branch & ex_mem_taken. Evaluated only when ex_mem_valid & state==IDLE.
// - Mispredict (mp) if any: pred_taken!=actual; pred_taken&actual&pred_target!=target;
//   !ex_mem_branch & btb_hit (alias).
// - Correct PC: actual ? ex_mem_target : ex_mem_pc+4 (mod 2^PC_WIDTH, wrap 0xFFC+4=0x000).
// - flush is combinational: high in detect cycle T (mp & IDLE) and whenever state!=IDLE.
// - FSM IDLE: on mp, latch redirect_pc, go REDIRECT at T+1. No mp: stay.
// - REDIRECT: redirect_valid=1, redirect_pc stable; on redirect_ready go DRAIN, counter=DRAIN_CYCLES-1.
//   redirect_ready with redirect_valid low is ignored.
// - DRAIN: decrement each cycle; at 0 go IDLE. redirect_valid=0.
// - Inputs during REDIRECT/DRAIN are wrong-path: no detection, no training, no counting.
// - Training (registered, asserted at T+1 for one cycle) when ex_mem_valid & IDLE:
//   branch: train_valid=1, train_taken=actual, train_alloc=actual&(!btb_hit|!pred_taken|target mismatch);
//   non-branch & btb_hit: train_valid=1, train_invalidate=1, train_taken=0.
// - Reset mid-operation: returns to IDLE immediately, pending redirect dropped.
// - Redirect latency: mp at T -> redirect_valid at T+1; min mispredict penalty 1+1+DRAIN_CYCLES.
// CONFIGURATION
// - BRU_PERF_CNT_EN defined: adds outputs perf_branches, perf_mispredicts (CNT_WIDTH each), counting
//   evaluated branches and mps; saturate at all-ones; cleared only by reset.
// - Undefined: counter logic and ports absent; all other behaviour identical.
// TESTING
// - Predicted not-taken, actual taken pc=0x100 target=0x040 -> flush at T, redirect_pc=0x040 at T+1, train_alloc=1.
// - Predicted taken, actual not-taken pc=0x0FC -> redirect_pc=0x100, train_taken=0, train_alloc=0.
// - Predicted taken target 0x080, actual 0x0C0 -> mp, redirect_pc=0x0C0; correct prediction -> no flush, train_valid only.
// - Non-branch btb_hit pc=0xFFC -> redirect_pc=0x000 (wrap), train_invalidate=1.
// - redirect_ready held low 5 cycles -> redirect_valid/redirect_pc stable, flush high; new mp inputs ignored.
// - Reset asserted in DRAIN -> all outputs 0 same cycle; BRU_PERF_CNT_EN: 3 branches/1 mp -> counters 3/1.

Source files
------------

// File: rtl/branch_resolution_unit.sv
// Branch resolution: checks EX/MEM outcome against fetch prediction, redirects fetch and trains predictor.
// Optional macro BRU_PERF_CNT_EN adds saturating branch/mispredict performance counters.
module branch_resolution_unit #(
    parameter int PC_WIDTH     = 12,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ex_mem_valid,
    input  logic [PC_WIDTH-1:0] ex_mem_pc,
    input  logic                ex_mem_branch,
    input  logic                ex_mem_taken,
    input  logic [PC_WIDTH-1:0] ex_mem_target,
    input  logic                ex_mem_pred_taken,
    input  logic [PC_WIDTH-1:0] ex_mem_pred_target,
    input  logic                ex_mem_btb_hit,
    input  logic                redirect_ready,
    output logic                redirect_valid,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic                flush,
    output logic                busy,
    output logic                train_valid,
    output logic                train_taken,
    output logic                train_alloc,
    output logic                train_invalidate
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] perf_branches,
    output logic [CNT_WIDTH-1:0] perf_mispredicts
`endif
);

    typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [3:0]    drain_cnt;
    logic          eval, actual, tgt_mis, mp, detect;
    logic [PC_WIDTH-1:0] correct_pc;

    // Reset gates evaluation so every output drops in the same cycle reset rises.
    assign eval       = ex_mem_valid & (state == IDLE) & ~reset;
    assign actual     = ex_mem_branch & ex_mem_taken;
    assign tgt_mis    = ex_mem_pred_target != ex_mem_target;
    assign mp         = (ex_mem_pred_taken != actual)
                      | (ex_mem_pred_taken & actual & tgt_mis)
                      | (~ex_mem_branch & ex_mem_btb_hit);
    assign detect     = eval & mp;
    assign correct_pc = actual ? ex_mem_target : ex_mem_pc + PC_WIDTH'(4);

    assign flush          = detect | (state != IDLE);
    assign busy           = state != IDLE;
    assign redirect_valid = state == REDIRECT;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (detect)          state_nxt = REDIRECT;
            REDIRECT: if (redirect_ready)  state_nxt = DRAIN;
            DRAIN:    if (drain_cnt == '0) state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            drain_cnt   <= '0;
            redirect_pc <= '0;
        end else begin
            state <= state_nxt;
            if (detect)
                redirect_pc <= correct_pc;
            if (state == REDIRECT && redirect_ready)
                drain_cnt <= 4'(DRAIN_CYCLES - 1);
            else if (state == DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - 4'd1;
        end
    end

    // Training strobes are recomputed every cycle, so each one lasts exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            train_valid      <= 1'b0;
            train_taken      <= 1'b0;
            train_alloc      <= 1'b0;
            train_invalidate <= 1'b0;
        end else begin
            train_valid      <= eval & (ex_mem_branch | ex_mem_btb_hit);
            train_taken      <= eval & actual;
            train_alloc      <= eval & ex_mem_branch & actual
                              & (~ex_mem_btb_hit | ~ex_mem_pred_taken | tgt_mis);
            train_invalidate <= eval & ~ex_mem_branch & ex_mem_btb_hit;
        end
    end

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (eval && ex_mem_branch && !(&perf_branches))
                perf_branches <= perf_branches + CNT_WIDTH'(1);
            if (detect && !(&perf_mispredicts))
                perf_mispredicts <= perf_mispredicts + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit with hand-computed expectations (DRAIN_CYCLES=2).
module tb_branch_resolution_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_mem_valid, ex_mem_branch, ex_mem_taken, ex_mem_pred_taken, ex_mem_btb_hit;
    logic [11:0] ex_mem_pc, ex_mem_target, ex_mem_pred_target;
    logic        redirect_ready;
    logic        redirect_valid, flush, busy;
    logic [11:0] redirect_pc;
    logic        train_valid, train_taken, train_alloc, train_invalidate;
`ifdef BRU_PERF_CNT_EN
    logic [15:0] perf_branches, perf_mispredicts;
`endif

    int checks = 0;
    int errors = 0;

    branch_resolution_unit dut (
        .clk(clk), .reset(reset),
        .ex_mem_valid(ex_mem_valid), .ex_mem_pc(ex_mem_pc), .ex_mem_branch(ex_mem_branch),
        .ex_mem_taken(ex_mem_taken), .ex_mem_target(ex_mem_target),
        .ex_mem_pred_taken(ex_mem_pred_taken), .ex_mem_pred_target(ex_mem_pred_target),
        .ex_mem_btb_hit(ex_mem_btb_hit), .redirect_ready(redirect_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush), .busy(busy),
        .train_valid(train_valid), .train_taken(train_taken), .train_alloc(train_alloc),
        .train_invalidate(train_invalidate)
`ifdef BRU_PERF_CNT_EN
        , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [11:0] pc, input logic br, input logic tk,
                         input logic [11:0] tgt, input logic ptk, input logic [11:0] ptgt,
                         input logic hit);
        ex_mem_valid = v; ex_mem_pc = pc; ex_mem_branch = br; ex_mem_taken = tk;
        ex_mem_target = tgt; ex_mem_pred_taken = ptk; ex_mem_pred_target = ptgt;
        ex_mem_btb_hit = hit;
    endtask

    task automatic idle_in();
        drive(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 1'b0, 12'h0, 1'b0);
    endtask

    task automatic chk_train(input string tag, input logic v, input logic tk, input logic al,
                             input logic inv);
        chk({tag, ".train_valid"}, {31'b0, train_valid}, {31'b0, v});
        chk({tag, ".train_taken"}, {31'b0, train_taken}, {31'b0, tk});
        chk({tag, ".train_alloc"}, {31'b0, train_alloc}, {31'b0, al});
        chk({tag, ".train_inval"}, {31'b0, train_invalidate}, {31'b0, inv});
    endtask

    // Handshake, then two drain cycles with flush high, then back to idle.
    task automatic handshake_drain(input string tag);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        chk({tag, ".drain_rv"}, {31'b0, redirect_valid}, 32'd0);
        chk({tag, ".drain_flush0"}, {31'b0, flush}, 32'd1);
        step();
        chk({tag, ".drain_flush1"}, {31'b0, flush}, 32'd1);
        step();
        chk({tag, ".idle_flush"}, {31'b0, flush}, 32'd0);
        chk({tag, ".idle_busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; redirect_ready = 1'b0; idle_in();
        #1;
        chk("rst.redirect_valid", {31'b0, redirect_valid}, 32'd0);
        chk("rst.redirect_pc", {20'b0, redirect_pc}, 32'd0);
        chk("rst.flush", {31'b0, flush}, 32'd0);
        chk("rst.busy", {31'b0, busy}, 32'd0);
        chk_train("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        step(); step();
        reset = 1'b0;
        step();

        // ready while idle is ignored
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        chk("rdy_idle.busy", {31'b0, busy}, 32'd0);
        chk("rdy_idle.rv", {31'b0, redirect_valid}, 32'd0);

        // 1: predicted not-taken, actually taken to 0x040
        drive(1'b1, 12'h100, 1'b1, 1'b1, 12'h040, 1'b0, 12'h000, 1'b0);
        #1;
        chk("t1.flush_T", {31'b0, flush}, 32'd1);
        chk("t1.rv_T", {31'b0, redirect_valid}, 32'd0);
        #1 step();
        idle_in();
        chk("t1.rv", {31'b0, redirect_valid}, 32'd1);
        chk("t1.rpc", {20'b0, redirect_pc}, 32'h040);
        chk("t1.busy", {31'b0, busy}, 32'd1);
        chk_train("t1", 1'b1, 1'b1, 1'b1, 1'b0);
        handshake_drain("t1");

        // 2: predicted taken, actually not-taken at 0x0FC -> fall through 0x100
        drive(1'b1, 12'h0FC, 1'b1, 1'b0, 12'h200, 1'b1, 12'h200, 1'b1);
        step();
        idle_in();
        chk("t2.rpc", {20'b0, redirect_pc}, 32'h100);
        chk_train("t2", 1'b1, 1'b0, 1'b0, 1'b0);
        handshake_drain("t2");

        // 3: taken, wrong predicted target; ready stalls five cycles under wrong-path traffic
        drive(1'b1, 12'h200, 1'b1, 1'b1, 12'h0C0, 1'b1, 12'h080, 1'b1);
        step();
        chk("t3.rpc", {20'b0, redirect_pc}, 32'h0C0);
        chk_train("t3", 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 12'h300, 1'b1, 1'b1, 12'h010, 1'b0, 12'h000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3.hold_rv", {31'b0, redirect_valid}, 32'd1);
            chk("t3.hold_rpc", {20'b0, redirect_pc}, 32'h0C0);
            chk("t3.hold_flush", {31'b0, flush}, 32'd1);
            chk("t3.hold_train", {31'b0, train_valid}, 32'd0);
        end
        idle_in();
        handshake_drain("t3");

        // 4: correct predictions -> no flush, training only
        drive(1'b1, 12'h400, 1'b1, 1'b1, 12'h500, 1'b1, 12'h500, 1'b1);
        #1;
        chk("t4.flush_T", {31'b0, flush}, 32'd0);
        #1 step();
        chk("t4.rv", {31'b0, redirect_valid}, 32'd0);
        chk("t4.busy", {31'b0, busy}, 32'd0);
        chk_train("t4a", 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 12'h404, 1'b1, 1'b0, 12'h600, 1'b0, 12'h000, 1'b0);
        step();
        idle_in();
        chk("t4b.flush", {31'b0, flush}, 32'd0);
        chk_train("t4b", 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("t4.train_clear", {31'b0, train_valid}, 32'd0);

        // 5: non-branch BTB alias at 0xFFC -> wrap to 0x000, invalidate
        drive(1'b1, 12'hFFC, 1'b0, 1'b0, 12'h000, 1'b1, 12'h123, 1'b1);
        #1;
        chk("t5.flush_T", {31'b0, flush}, 32'd1);
        #1 step();
        idle_in();
        chk("t5.rpc", {20'b0, redirect_pc}, 32'h000);
        chk("t5.rv", {31'b0, redirect_valid}, 32'd1);
        chk_train("t5", 1'b1, 1'b0, 1'b0, 1'b1);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        chk("t5.in_drain", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_drain.busy", {31'b0, busy}, 32'd0);
        chk("rst_drain.flush", {31'b0, flush}, 32'd0);
        chk("rst_drain.rv", {31'b0, redirect_valid}, 32'd0);
        chk("rst_drain.rpc", {20'b0, redirect_pc}, 32'd0);
        step();
        reset = 1'b0;
        step();

        // 6: three branches, one mispredict
        drive(1'b1, 12'h400, 1'b1, 1'b1, 12'h500, 1'b1, 12'h500, 1'b1);
        step();
        drive(1'b1, 12'h404, 1'b1, 1'b0, 12'h600, 1'b0, 12'h000, 1'b0);
        step();
        drive(1'b1, 12'h408, 1'b1, 1'b1, 12'h700, 1'b0, 12'h000, 1'b0);
        step();
        idle_in();
        chk("t6.rpc", {20'b0, redirect_pc}, 32'h700);
`ifdef BRU_PERF_CNT_EN
        chk("t6.perf_branches", {16'b0, perf_branches}, 32'd3);
        chk("t6.perf_mispredicts", {16'b0, perf_mispredicts}, 32'd1);
`endif
        handshake_drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
